hilo_mult_ctrl: RTL and testbench
=================================

// Module: hilo_mult_ctrl
// PURPOSE
//  Multi-cycle sequencer and owner of the HI/LO register pair for the MIPS datapath.
//  - Accepts multiply-class ops from the EX stage: MULT, MULTU, MADD, MSUB, MTHI, MTLO.
//  - Runs multiplies iteratively (shift-add) instead of in one combinational cycle.
//  - Holds HI/LO and raises an interlock (Stall) while busy, so MFHI/MFLO and new ops wait.
// PARAMETERS
//  WIDTH          32  operand/HI/LO width
//  BITS_PER_CYCLE 1   multiplier bits retired per CALC cycle; must divide WIDTH
//                     (ITERS = WIDTH/BITS_PER_CYCLE)
// PORTS
//  Clk      in   1      single clock; all state updates on rising edge
//  Reset    in   1      synchronous reset, active-low (0 = reset, sampled on Clk rising edge)
//  Start    in   1      op request valid this cycle
//  Op       in   3      000 MULT, 001 MULTU, 010 MADD, 011 MSUB, 100 MTHI, 101 MTLO, 11x no-op
//  A        in   WIDTH  rs operand (also MTHI/MTLO source)
//  B        in   WIDTH  rt operand
//  RdReq    in   1      EX/ID stage wants HI or LO this cycle (MFHI/MFLO)
//  HI       out  WIDTH  registered HI
//  LO       out  WIDTH  registered LO
//  Busy     out  1      multiply in flight
//  Done     out  1      one-cycle pulse: HI/LO just updated by a multiply
//  Stall    out  1      combinational: Busy & (Start | RdReq); pipeline must hold
// BEHAVIOUR
//  Reset (Reset==0 at an edge): state=IDLE, HI=LO=0, Busy=0, Done=0, iteration count=0.
//   Reset overrides everything, including a multiply in flight; the op is discarded.
//  FSM states: IDLE -> CALC -> FINISH -> IDLE.
//  IDLE:
//   - Start & Op=MTHI: HI<=A. Start & Op=MTLO: LO<=A. Both complete on that edge;
//     no Busy, no Done.
//   - Start & multiply op: latch op, |A|,|B| (magnitudes for signed ops; |0x80000000| =
//     2^31 unsigned) and result sign (A[31]^B[31], signed ops only). Clear 2*WIDTH
//     partial product. Go to CALC; Busy=1 from next cycle.
//   - Start & no-op: ignored.
//  CALC: ITERS cycles, each adds BITS_PER_CYCLE multiplier bits into the partial product
//   (unsigned shift-add). After the last iteration go to FINISH.
//  FINISH (one cycle): P = sign ? -prod : prod (mod 2^(2*WIDTH)). Then on the edge:
//   - MULT/MULTU: {HI,LO}<=P.  MADD: {HI,LO}<={HI,LO}+P.  MSUB: {HI,LO}<={HI,LO}-P.
//   - All results are mod 2^(2*WIDTH); no overflow flags.
//   - Then Busy<=0, Done<=1 for exactly one cycle, state<=IDLE.
//  Latency: Start accepted at edge E0; HI/LO valid and Done=1 after edge E(ITERS+1)
//   (E33 at defaults). Busy is high for exactly ITERS+1 cycles.
//  Start/RdReq while Busy: Stall=1, request not consumed; requester holds Start/Op/A/B.
//   Start in the Done cycle is accepted normally (Busy=0 there).
//  HI/LO do not change during CALC, so MADD/MSUB accumulate onto the values present at Start.
//  MTHI/MTLO never stall in IDLE. Stall is never asserted in IDLE.
// STRUCTURE
//  Package hilo_pkg:
//   - localparam op codes OP_MULT..OP_MTLO
//   - FSM state encoding S_IDLE/S_CALC/S_FINISH
//   - ITERS derivation and counter width ($clog2(ITERS+1))
//  Sub-module mult_iter_core: iterative unsigned shift-add datapath.
//   - Inputs: load, step, multiplicand, multiplier.
//   - Outputs: 2*WIDTH product.
//  hilo_mult_ctrl contains the FSM, the sign/accumulate logic in FINISH, HI/LO regs and
//   the Stall logic.
// TESTING
//  1 MULT A=FFFFFFFF, B=00000002 -> Done after 33 cycles; HI=FFFFFFFF, LO=FFFFFFFE.
//  2 MULTU same operands -> HI=00000001, LO=FFFFFFFE.
//    MULT A=B=80000000 -> HI=40000000, LO=00000000.
//  3 MTHI A=0, MTLO A=5, then MADD A=3, B=4 -> HI=0, LO=00000011.
//    Then MSUB A=1, B=0x11 -> HI=LO=0.
//  4 MTHI=MTLO=0, MSUB A=1, B=1 -> HI=FFFFFFFF, LO=FFFFFFFF.
//    MULT A=-3, B=7 -> HI=FFFFFFFF, LO=FFFFFFEB.
//  5 Start MULT, then assert Start (MTLO) and RdReq at cycle 5 ->
//    - Stall=1 each cycle until Done.
//    - LO is unchanged by the MTLO until it is accepted in the Done cycle.
//  6 Start MULT, drive Reset=0 at cycle 10 -> next cycle: Busy=0, HI=LO=0, no Done pulse.
//    Then MULT 6*7 completes normally with LO=0000002A.

Source files
------------

// File: rtl/hilo_mult_ctrl_pkg.sv
// ============================================================================
// Module : hilo_pkg
// Brief  : Op codes, FSM encoding and iteration sizing for the HI/LO sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package hilo_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MADD  = 3'b010;
    localparam logic [2:0] OP_MSUB  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    function automatic int calc_iters(input int width, input int bits_per_cycle);
        return width / bits_per_cycle;
    endfunction

    function automatic int calc_cnt_w(input int iters);
        return $clog2(iters + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hilo_mult_ctrl_if.sv
// ============================================================================
// Module : hilo_mult_ctrl_if
// Brief  : EX-stage request / HI-LO result bundle for the multiply sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface hilo_mult_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             i_start;
    logic [2:0]       i_op;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_rd_req;
    logic [WIDTH-1:0] o_hi;
    logic [WIDTH-1:0] o_lo;
    logic             o_busy;
    logic             o_done;
    logic             o_stall;

    modport master (
        output i_start, i_op, i_a, i_b, i_rd_req,
        input  o_hi, o_lo, o_busy, o_done, o_stall
    );

    modport slave (
        input  i_start, i_op, i_a, i_b, i_rd_req,
        output o_hi, o_lo, o_busy, o_done, o_stall
    );
endinterface

`default_nettype wire

// File: rtl/hilo_mult_ctrl_mult_iter_core.sv
// ============================================================================
// Module : mult_iter_core
// Brief  : Iterative unsigned shift-add multiplier, BITS_PER_CYCLE bits/step.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mult_iter_core #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  wire logic               i_clk,
    input  wire logic               i_rst_n,
    input  wire logic               i_load,
    input  wire logic               i_step,
    input  wire logic [WIDTH-1:0]   i_multiplicand,
    input  wire logic [WIDTH-1:0]   i_multiplier,
    output logic [2*WIDTH-1:0]      o_product
);

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_prod;
    logic [2*WIDTH-1:0] w_sum;

    // Multiplicand walks left as multiplier bits are consumed from the LSB end.
    always_comb begin
        w_sum = r_prod;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (r_mplier[k]) begin
                w_sum = w_sum + (r_mcand << k);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
        end else if (i_load) begin
            r_mcand  <= {{WIDTH{1'b0}}, i_multiplicand};
            r_mplier <= i_multiplier;
            r_prod   <= '0;
        end else if (i_step) begin
            r_mcand  <= r_mcand << BITS_PER_CYCLE;
            r_mplier <= r_mplier >> BITS_PER_CYCLE;
            r_prod   <= w_sum;
        end
    end

    assign o_product = r_prod;

endmodule

`default_nettype wire

// File: rtl/hilo_mult_ctrl.sv
// ============================================================================
// Module : hilo_mult_ctrl
// Brief  : HI/LO owner and multi-cycle MULT/MULTU/MADD/MSUB sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module hilo_mult_ctrl
    import hilo_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  wire logic          i_clk,
    input  wire logic          i_rst_n,
    hilo_mult_ctrl_if.slave    bus
);

    localparam int ITERS = calc_iters(WIDTH, BITS_PER_CYCLE);
    localparam int CNT_W = calc_cnt_w(ITERS);

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [2:0]         r_op, w_op_nxt;
    logic               r_sign, w_sign_nxt;
    logic [WIDTH-1:0]   r_hi, w_hi_nxt, r_lo, w_lo_nxt;
    logic               r_busy, w_busy_nxt, r_done, w_done_nxt;
    logic               w_load, w_step, w_signed;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b;
    logic [2*WIDTH-1:0] w_prod, w_p, w_res;

    // Negating the most-negative value yields the same bits, read as 2^(WIDTH-1).
    assign w_mag_a = (w_signed && bus.i_a[WIDTH-1]) ? -bus.i_a : bus.i_a;
    assign w_mag_b = (w_signed && bus.i_b[WIDTH-1]) ? -bus.i_b : bus.i_b;
    assign w_p     = r_sign ? -w_prod : w_prod;

    always_comb begin
        case (r_op)
            OP_MADD: w_res = {r_hi, r_lo} + w_p;
            OP_MSUB: w_res = {r_hi, r_lo} - w_p;
            default: w_res = w_p;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        w_sign_nxt  = r_sign;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_signed    = (bus.i_op != OP_MULTU);
        case (r_state)
            S_IDLE: begin
                if (bus.i_start) begin
                    case (bus.i_op)
                        OP_MTHI: w_hi_nxt = bus.i_a;
                        OP_MTLO: w_lo_nxt = bus.i_a;
                        OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
                            w_load      = 1'b1;
                            w_op_nxt    = bus.i_op;
                            w_sign_nxt  = w_signed & (bus.i_a[WIDTH-1] ^ bus.i_b[WIDTH-1]);
                            w_cnt_nxt   = '0;
                            w_busy_nxt  = 1'b1;
                            w_state_nxt = S_CALC;
                        end
                        default: ;
                    endcase
                end
            end
            S_CALC: begin
                w_step    = 1'b1;
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == CNT_W'(ITERS - 1)) begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                w_hi_nxt    = w_res[2*WIDTH-1:WIDTH];
                w_lo_nxt    = w_res[WIDTH-1:0];
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= OP_MULT;
            r_sign  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
            r_sign  <= w_sign_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    mult_iter_core #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_core (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_load         (w_load),
        .i_step         (w_step),
        .i_multiplicand (w_mag_a),
        .i_multiplier   (w_mag_b),
        .o_product      (w_prod)
    );

    assign bus.o_hi    = r_hi;
    assign bus.o_lo    = r_lo;
    assign bus.o_busy  = r_busy;
    assign bus.o_done  = r_done;
    assign bus.o_stall = r_busy & (bus.i_start | bus.i_rd_req);

endmodule

`default_nettype wire

// File: tb/tb_hilo_mult_ctrl.sv
// ============================================================================
// Module : tb_hilo_mult_ctrl
// Brief  : Directed-vector bench for the HI/LO multiply sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_hilo_mult_ctrl;
    import hilo_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    hilo_mult_ctrl_if #(.WIDTH(32)) bus ();

    hilo_mult_ctrl #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic move_to(input logic [2:0] op, input logic [31:0] a);
        bus.i_start = 1'b1;
        bus.i_op    = op;
        bus.i_a     = a;
        bus.i_b     = '0;
        tick();
        bus.i_start = 1'b0;
        check_eq("move_busy", 64'(bus.o_busy), 64'd0);
    endtask

    // Issue a multiply-class op and wait (bounded) for Done; latency must be 33.
    task automatic run_mult(input string tag, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_hi,
                            input logic [31:0] exp_lo);
        int n;
        bus.i_start = 1'b1;
        bus.i_op    = op;
        bus.i_a     = a;
        bus.i_b     = b;
        tick();
        bus.i_start = 1'b0;
        n = 0;
        while (!bus.o_done && n < 100) begin
            tick();
            n++;
        end
        check_eq({tag, "_latency"}, 64'(n), 64'd33);
        check_eq({tag, "_hi"}, 64'(bus.o_hi), 64'(exp_hi));
        check_eq({tag, "_lo"}, 64'(bus.o_lo), 64'(exp_lo));
        tick();
        check_eq({tag, "_done_pulse"}, 64'(bus.o_done), 64'd0);
    endtask

    initial begin
        int n;
        rst_n        = 1'b0;
        bus.i_start  = 1'b0;
        bus.i_op     = 3'b111;
        bus.i_a      = '0;
        bus.i_b      = '0;
        bus.i_rd_req = 1'b0;
        tick();
        tick();
        check_eq("rst_hi", 64'(bus.o_hi), 64'd0);
        check_eq("rst_lo", 64'(bus.o_lo), 64'd0);
        check_eq("rst_busy", 64'(bus.o_busy), 64'd0);
        check_eq("rst_done", 64'(bus.o_done), 64'd0);
        rst_n = 1'b1;
        tick();

        // Stall never asserts while idle.
        bus.i_rd_req = 1'b1;
        #1;
        check_eq("idle_stall", 64'(bus.o_stall), 64'd0);
        bus.i_rd_req = 1'b0;

        run_mult("t1_mult", OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_mult("t2_multu", OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE);
        run_mult("t2_minneg", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);

        move_to(OP_MTHI, 32'h0);
        move_to(OP_MTLO, 32'h5);
        check_eq("t3_mtlo", 64'(bus.o_lo), 64'h5);
        run_mult("t3_madd", OP_MADD, 32'd3, 32'd4, 32'h0, 32'h0000_0011);
        run_mult("t3_msub", OP_MSUB, 32'd1, 32'h11, 32'h0, 32'h0);

        move_to(OP_MTHI, 32'h0);
        move_to(OP_MTLO, 32'h0);
        run_mult("t4_msub", OP_MSUB, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_mult("t4_mult", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        // Test 5: MTLO + RdReq held from cycle 5 of an in-flight MULT 6*7.
        bus.i_start = 1'b1;
        bus.i_op    = OP_MULT;
        bus.i_a     = 32'd6;
        bus.i_b     = 32'd7;
        tick();
        bus.i_start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        bus.i_start  = 1'b1;
        bus.i_op     = OP_MTLO;
        bus.i_a      = 32'h0000_0123;
        bus.i_b      = '0;
        bus.i_rd_req = 1'b1;
        #1;
        n = 0;
        while (!bus.o_done && n < 100) begin
            check_eq("t5_stall", 64'(bus.o_stall), 64'd1);
            check_eq("t5_lo_hold", 64'(bus.o_lo), 64'hFFFF_FFEB);
            tick();
            n++;
        end
        check_eq("t5_wait", 64'(n < 100), 64'd1);
        check_eq("t5_done_stall", 64'(bus.o_stall), 64'd0);
        check_eq("t5_done_lo", 64'(bus.o_lo), 64'h2A);
        tick();
        bus.i_start  = 1'b0;
        bus.i_rd_req = 1'b0;
        check_eq("t5_mtlo_lo", 64'(bus.o_lo), 64'h123);
        check_eq("t5_mtlo_busy", 64'(bus.o_busy), 64'd0);

        // Test 6: reset mid-multiply discards the op.
        bus.i_start = 1'b1;
        bus.i_op    = OP_MULT;
        bus.i_a     = 32'd9;
        bus.i_b     = 32'd9;
        tick();
        bus.i_start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check_eq("t6_busy_before", 64'(bus.o_busy), 64'd1);
        rst_n = 1'b0;
        tick();
        check_eq("t6_busy", 64'(bus.o_busy), 64'd0);
        check_eq("t6_hi", 64'(bus.o_hi), 64'd0);
        check_eq("t6_lo", 64'(bus.o_lo), 64'd0);
        check_eq("t6_done", 64'(bus.o_done), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            check_eq("t6_no_done", 64'(bus.o_done), 64'd0);
        end
        run_mult("t6_mult", OP_MULT, 32'd6, 32'd7, 32'h0, 32'h0000_002A);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
